// File: rtl/remote_key_event_pkg.sv
// Shared definitions for the IR key-event stage: FSM state encodings,
// NEC protocol timing and small arithmetic helpers.
package remote_key_event_pkg;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Interval between NEC repeat codes while a key is kept down
  localparam int NEC_REPEAT_MS = 108;

  // 16-bit increment that sticks at the maximum instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/remote_key_event_ms_tick_gen.sv
// Millisecond time base: a prescaler counting 0..CLK_FREQ/1000-1 that emits
// a registered 1-cycle tick in the cycle the count sits at its last value.
// A synchronous clear restarts the count so timeouts measured from a clear
// are cycle-exact. CLK_FREQ/1000 must be at least 2.
module ms_tick_gen #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV = CLK_FREQ / 1000;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and tick: tick is raised one cycle ahead so it lines up with the last count
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = (cnt_q == CNT_PRE);
    end
  end

  // Prescaler registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/remote_key_event.sv
// Key-event stage behind the NEC IR decoder. Converts raw data_en/repeat_en
// pulses into press / hold / release events, counts fresh presses and
// presents the key code to the 7-segment display.
// Release is detected by timeout because NEC sends no release frame.
// Optional feature macro: IR_AUTOREPEAT_EN (auto-repeat key_valid in HOLD).
module remote_key_event
  import remote_key_event_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int RELEASE_MS = 120,
  parameter int HOLD_MS    = 500,
  parameter int RPT_MS     = 200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        data_en,
  input  logic [7:0]  data,
  input  logic        repeat_en,
  output logic [7:0]  key_code,
  output logic        key_valid,
  output logic        key_rpt,
  output logic        key_held,
  output logic        key_release,
  output logic [15:0] press_cnt,
  output logic [19:0] disp_data
);

  // A timeout "reaches" its limit on the tick that moves the counter from limit-1 to limit
  localparam logic [15:0] REL_LAST  = 16'(RELEASE_MS - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);
  localparam logic [15:0] RPT_LAST  = 16'(RPT_MS - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_rpt_q, key_rpt_d;
  logic        key_held_q, key_held_d;
  logic        key_release_q, key_release_d;
  logic [15:0] press_cnt_q, press_cnt_d;
  logic [15:0] evt_ms_q, evt_ms_d;
  logic [15:0] press_ms_q, press_ms_d;

  logic        tick_s;
  logic        clr_s;
  logic        active_s;
  logic        rel_hit_s;
  logic        hold_hit_s;
  logic        rpt_hit_s;

  ms_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .clr_i  (clr_s),
    .tick_o (tick_s)
  );

  assign active_s   = (state_q != ST_IDLE);
  assign rel_hit_s  = active_s && tick_s && (evt_ms_q == REL_LAST);
  assign hold_hit_s = (state_q == ST_PRESS) && tick_s && (press_ms_q == HOLD_LAST);
  // The hold timer keeps an RPT_MS cadence in HOLD; it only drives outputs with auto-repeat
  assign rpt_hit_s  = (state_q == ST_HOLD) && tick_s && (press_ms_q == RPT_LAST);

  // FSM, timers and next output values, resolved in priority order
  always_comb begin
    state_d       = state_q;
    key_code_d    = key_code_q;
    press_cnt_d   = press_cnt_q;
    key_valid_d   = 1'b0;
    key_rpt_d     = 1'b0;
    key_release_d = 1'b0;
    clr_s         = 1'b0;
    evt_ms_d      = tick_s ? sat_inc16(evt_ms_q) : evt_ms_q;
    press_ms_d    = tick_s ? sat_inc16(press_ms_q) : press_ms_q;

    if (data_en) begin
      // Any decoded frame is a fresh press; an active key is released in the same cycle
      key_release_d = active_s;
      key_valid_d   = 1'b1;
      key_code_d    = data;
      press_cnt_d   = press_cnt_q + 16'd1;
      evt_ms_d      = 16'd0;
      press_ms_d    = 16'd0;
      clr_s         = 1'b1;
      state_d       = ST_PRESS;
    end else if (rel_hit_s) begin
      // No repeat arrived in time: the key was let go, code stays on display
      key_release_d = 1'b1;
      state_d       = ST_IDLE;
    end else if (hold_hit_s) begin
      state_d    = ST_HOLD;
      press_ms_d = 16'd0;
`ifdef IR_AUTOREPEAT_EN
      key_valid_d = 1'b1;
      key_rpt_d   = 1'b1;
`else
      key_rpt_d   = 1'b0;
`endif
    end else if (rpt_hit_s) begin
      press_ms_d = 16'd0;
`ifdef IR_AUTOREPEAT_EN
      key_valid_d = 1'b1;
      key_rpt_d   = 1'b1;
`else
      key_rpt_d   = 1'b0;
`endif
    end else if (repeat_en && active_s) begin
      // Repeat code keeps the key alive; orphan repeats in IDLE fall through
      evt_ms_d = 16'd0;
      clr_s    = 1'b1;
    end else begin
      state_d = state_q;
    end

    key_held_d = (state_d == ST_HOLD);
  end

  // State, timer and output registers with synchronous active-low reset
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      key_code_q    <= 8'd0;
      key_valid_q   <= 1'b0;
      key_rpt_q     <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
      press_cnt_q   <= 16'd0;
      evt_ms_q      <= 16'd0;
      press_ms_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_rpt_q     <= key_rpt_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
      press_cnt_q   <= press_cnt_d;
      evt_ms_q      <= evt_ms_d;
      press_ms_q    <= press_ms_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_rpt     = key_rpt_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;
  assign press_cnt   = press_cnt_q;
  assign disp_data   = {12'd0, key_code_q};

endmodule
